// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch front end. Owns the fetch PC, requests
// words from the icache, queries the branch predictor for conditional
// branches, computes the predicted next PC and dispatches to the IQ.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if2icache_en,
  output logic [31:0] if2icache_PC,
  input  logic        icache2if_valid,
  input  logic [31:0] icache2if_inst,
  output logic        if2pred_en,
  output logic [31:0] if2pre_PC,
  input  logic        prediction,
  input  logic        iq_full,
  output logic        if2iq_valid,
  output logic [31:0] if2iq_inst,
  output logic [31:0] if2iq_PC,
  output logic        if2iq_pred_taken,
  output logic [31:0] if2iq_pred_PC,
  input  logic        alu2if_jalr_en,
  input  logic [31:0] alu2if_jalr_PC,
  input  logic        rob2if_flush,
  input  logic [31:0] rob2if_target
);

  typedef enum logic [1:0] {
    REDIRECT,
    FETCH,
    HOLD,
    JALR_WAIT
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_q, held_d;
  logic        iq_valid_q, iq_valid_d;
  logic [31:0] iq_inst_q, iq_inst_d;
  logic [31:0] iq_pc_q, iq_pc_d;
  logic        iq_taken_q, iq_taken_d;
  logic [31:0] iq_pred_pc_q, iq_pred_pc_d;

  logic        dispatch;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [31:0] imm_b, imm_j;
  logic [31:0] next_pc;
  logic        taken;

  // Decode the instruction being dispatched this cycle and its predicted successor.
  always_comb begin
    inst     = (state_q == HOLD) ? held_q : icache2if_inst;
    opcode   = inst[6:0];
    imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    dispatch = rdy_in && !rst_in && !rob2if_flush && !iq_full &&
               (((state_q == FETCH) && icache2if_valid) || (state_q == HOLD));
    taken    = 1'b0;
    next_pc  = pc_q + 32'd4;
    case (opcode)
      OP_BRANCH: begin
        taken = prediction;
        if (prediction) next_pc = pc_q + imm_b;
      end
      OP_JAL: begin
        taken   = 1'b1;
        next_pc = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  // Request, predictor-query and IQ-facing outputs.
  always_comb begin
    if2icache_en     = (state_q == FETCH);
    if2icache_PC     = if2icache_en ? pc_q : '0;
    if2pred_en       = dispatch && (opcode == OP_BRANCH);
    if2pre_PC        = if2pred_en ? pc_q : '0;
    if2iq_valid      = iq_valid_q && rdy_in;
    if2iq_inst       = iq_inst_q;
    if2iq_PC         = iq_pc_q;
    if2iq_pred_taken = iq_taken_q;
    if2iq_pred_PC    = iq_pred_pc_q;
  end

  // Next-state: flush beats everything; rdy_in low freezes every register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    held_d       = held_q;
    iq_valid_d   = iq_valid_q;
    iq_inst_d    = iq_inst_q;
    iq_pc_d      = iq_pc_q;
    iq_taken_d   = iq_taken_q;
    iq_pred_pc_d = iq_pred_pc_q;
    if (rdy_in) begin
      if (rob2if_flush) begin
        pc_d       = rob2if_target;
        state_d    = REDIRECT;
        iq_valid_d = 1'b0;
      end else begin
        iq_valid_d = dispatch;
        case (state_q)
          REDIRECT: state_d = FETCH;
          FETCH: begin
            if (icache2if_valid && iq_full) begin
              held_d  = icache2if_inst;
              state_d = HOLD;
            end
          end
          HOLD: ;
          JALR_WAIT: begin
            if (alu2if_jalr_en) begin
              pc_d    = alu2if_jalr_PC;
              state_d = FETCH;
            end
          end
          default: state_d = REDIRECT;
        endcase
        if (dispatch) begin
          iq_inst_d    = inst;
          iq_pc_d      = pc_q;
          iq_taken_d   = taken;
          iq_pred_pc_d = next_pc;
          pc_d         = next_pc;
          state_d      = (opcode == OP_JALR) ? JALR_WAIT : FETCH;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= REDIRECT;
      pc_q         <= RESET_PC;
      held_q       <= '0;
      iq_valid_q   <= 1'b0;
      iq_inst_q    <= '0;
      iq_pc_q      <= '0;
      iq_taken_q   <= 1'b0;
      iq_pred_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      held_q       <= held_d;
      iq_valid_q   <= iq_valid_d;
      iq_inst_q    <= iq_inst_d;
      iq_pc_q      <= iq_pc_d;
      iq_taken_q   <= iq_taken_d;
      iq_pred_pc_q <= iq_pred_pc_d;
    end
  end

endmodule
